// File: rtl/cp0_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_gen
//  Brief    : Parametrised MIPS coprocessor 0 (SR, Cause, EPC, PRId,
//             BadVAddr, Count/Compare). Optional timer: `define CP0_TIMER_EN.
//  Revision : 1.0  initial release
// ============================================================================
module cp0_gen #(
    parameter int          NUM_HWINT  = 6,
    parameter logic [31:0] PRID_VAL   = 32'h0000_4E59,
    parameter int          TIMER_LINE = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           rd_addr,
    output logic [31:0]          rd_data,
    input  logic                 wr_en,
    input  logic [4:0]           wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 exc_begin,
    input  logic [4:0]           exc_code,
    input  logic                 exc_bd,
    input  logic [31:0]          exc_pc,
    input  logic [31:0]          exc_badvaddr,
    input  logic                 exc_bad_vld,
    input  logic                 eret,
    output logic                 int_req,
    output logic [31:0]          epc_out,
    output logic                 exl_out
);

    localparam logic [4:0] c_BADVADDR = 5'd8;
    localparam logic [4:0] c_COUNT    = 5'd9;
    localparam logic [4:0] c_COMPARE  = 5'd11;
    localparam logic [4:0] c_SR       = 5'd12;
    localparam logic [4:0] c_CAUSE    = 5'd13;
    localparam logic [4:0] c_EPC      = 5'd14;
    localparam logic [4:0] c_PRID     = 5'd15;

    logic [7:0]           r_im;
    logic                 r_exl;
    logic                 r_ie;
    logic                 r_bd;
    logic [4:0]           r_exc_code;
    logic [NUM_HWINT-1:0] r_ip;
    logic [29:0]          r_epc;
    logic [31:0]          r_badvaddr;

    logic                 w_ti;
    logic [31:0]          w_count_rd;
    logic [31:0]          w_compare_rd;
    logic [NUM_HWINT-1:0] w_ti_vec;
    logic [NUM_HWINT-1:0] w_ip_live;
    logic [7:0]           w_ip_field;
    logic                 w_wr_sr;
    logic                 w_wr_cause;
    logic                 w_wr_epc;
    logic                 w_exc_first;
    logic                 w_unused;

    assign w_wr_sr     = wr_en && (wr_addr == c_SR);
    assign w_wr_cause  = wr_en && (wr_addr == c_CAUSE);
    assign w_wr_epc    = wr_en && (wr_addr == c_EPC);
    // Only a non-nested entry records the return point and delay-slot flag.
    assign w_exc_first = exc_begin && !r_exl;
    assign w_unused    = ^exc_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_exc_code <= 5'd0;
            r_ip       <= '0;
            r_epc      <= 30'd0;
            r_badvaddr <= 32'd0;
        end else begin
            if (exc_begin) begin
                r_exl <= 1'b1;
            end else if (eret) begin
                r_exl <= 1'b0;
            end else if (w_wr_sr) begin
                r_exl <= wr_data[1];
            end

            if (w_wr_sr) begin
                r_im <= wr_data[15:8];
                r_ie <= wr_data[0];
            end

            if (exc_begin) begin
                r_exc_code <= exc_code;
            end else if (w_wr_cause) begin
                r_exc_code <= wr_data[6:2];
            end

            if (w_exc_first) begin
                r_bd <= exc_bd;
            end else if (w_wr_cause) begin
                r_bd <= wr_data[31];
            end

            // EPC low bits always read as zero, so only [31:2] is stored.
            if (w_exc_first) begin
                r_epc <= exc_bd ? (exc_pc[31:2] - 30'd1) : exc_pc[31:2];
            end else if (w_wr_epc) begin
                r_epc <= wr_data[31:2];
            end

            if (exc_begin && exc_bad_vld) begin
                r_badvaddr <= exc_badvaddr;
            end

            r_ip <= w_ip_live;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_wr_count   = wr_en && (wr_addr == c_COUNT);
    assign w_wr_compare = wr_en && (wr_addr == c_COMPARE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            if (w_wr_count) begin
                r_count <= wr_data;
            end else begin
                r_count <= r_count + 32'd1;
            end

            if (w_wr_compare) begin
                r_compare <= wr_data;
            end

            // Writing Compare acknowledges the timer and beats a coincident match.
            if (w_wr_compare) begin
                r_ti <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_ti         = r_ti;
    assign w_count_rd   = r_count;
    assign w_compare_rd = r_compare;
`else
    assign w_ti         = 1'b0;
    assign w_count_rd   = 32'd0;
    assign w_compare_rd = 32'd0;
`endif

    assign w_ti_vec  = NUM_HWINT'(w_ti) << TIMER_LINE;
    assign w_ip_live = hw_int | w_ti_vec;

    always_comb begin
        w_ip_field                  = 8'd0;
        w_ip_field[2 +: NUM_HWINT]  = r_ip;
    end

    // Interrupt request uses the live lines, not the registered IP copy.
    assign int_req = (|(r_im[2 +: NUM_HWINT] & w_ip_live)) & r_ie & ~r_exl;
    assign epc_out = {r_epc, 2'b00};
    assign exl_out = r_exl;

    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            c_BADVADDR: rd_data = r_badvaddr;
            c_COUNT:    rd_data = w_count_rd;
            c_COMPARE:  rd_data = w_compare_rd;
            c_SR:       rd_data = {16'd0, r_im, 6'd0, r_exl, r_ie};
            c_CAUSE:    rd_data = {r_bd, w_ti, 14'd0, w_ip_field, 1'b0, r_exc_code, 2'b00};
            c_EPC:      rd_data = {r_epc, 2'b00};
            c_PRID:     rd_data = PRID_VAL;
            default:    rd_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp0_gen
//  Brief    : Self-checking bench for cp0_gen (vector table + scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cp0_gen;

`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [5:0]  hw_int;
    logic        exc_begin;
    logic [4:0]  exc_code;
    logic        exc_bd;
    logic [31:0] exc_pc;
    logic [31:0] exc_badvaddr;
    logic        exc_bad_vld;
    logic        eret;
    logic        int_req;
    logic [31:0] epc_out;
    logic        exl_out;

    cp0_gen #(
        .NUM_HWINT  (6),
        .PRID_VAL   (32'h0000_4E59),
        .TIMER_LINE (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .hw_int       (hw_int),
        .exc_begin    (exc_begin),
        .exc_code     (exc_code),
        .exc_bd       (exc_bd),
        .exc_pc       (exc_pc),
        .exc_badvaddr (exc_badvaddr),
        .exc_bad_vld  (exc_bad_vld),
        .eret         (eret),
        .int_req      (int_req),
        .epc_out      (epc_out),
        .exl_out      (exl_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [5:0]  hw;
        logic        eb;
        logic [4:0]  ec;
        logic        ebd;
        logic [31:0] pc;
        logic [31:0] bva;
        logic        bvld;
        logic        er;
        logic [4:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_irq;
        logic        exp_exl;
        logic [31:0] exp_epc;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic        exl;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[22];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t V(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [5:0] hw, input logic eb, input logic [4:0] ec,
                               input logic ebd, input logic [31:0] pc, input logic [31:0] bva,
                               input logic bvld, input logic er, input logic [4:0] ra,
                               input logic [31:0] erd, input logic eirq, input logic eexl,
                               input logic [31:0] eepc);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.hw = hw; v.eb = eb; v.ec = ec; v.ebd = ebd;
        v.pc = pc; v.bva = bva; v.bvld = bvld; v.er = er; v.ra = ra;
        v.exp_rd = erd; v.exp_irq = eirq; v.exp_exl = eexl; v.exp_epc = eepc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one vector for one clock; expected post-edge state goes through the scoreboard.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        wr_en = v.we; wr_addr = v.wa; wr_data = v.wd; hw_int = v.hw;
        exc_begin = v.eb; exc_code = v.ec; exc_bd = v.ebd; exc_pc = v.pc;
        exc_badvaddr = v.bva; exc_bad_vld = v.bvld; eret = v.er; rd_addr = v.ra;
        e.rd = v.exp_rd; e.irq = v.exp_irq; e.exl = v.exp_exl; e.epc = v.exp_epc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        wr_en = 1'b0; exc_begin = 1'b0; eret = 1'b0;
        got = exp_q.pop_front();
        check({tag, ".rd"},  rd_data, got.rd);
        check({tag, ".irq"}, {31'd0, int_req}, {31'd0, got.irq});
        check({tag, ".exl"}, {31'd0, exl_out}, {31'd0, got.exl});
        check({tag, ".epc"}, epc_out, got.epc);
    endtask

    initial begin
        int n;
        reset = 1'b1; rd_addr = 5'd0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        hw_int = 6'd0; exc_begin = 1'b0; exc_code = 5'd0; exc_bd = 1'b0; exc_pc = 32'd0;
        exc_badvaddr = 32'd0; exc_bad_vld = 1'b0; eret = 1'b0;

        //            we  wa     wd            hw      eb ec    ebd pc            bva         bvld er ra     exp_rd                       irq exl epc
        vecs[0]  = V(1, 5'd11, 32'hFFFF_0000, 6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd11, TIMER ? 32'hFFFF_0000 : 32'h0, 0, 0, 32'h0);
        vecs[1]  = V(1, 5'd12, 32'h0000_FC01, 6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd12, 32'h0000_FC01, 0, 0, 32'h0);
        vecs[2]  = V(0, 5'd0,  32'h0,         6'h04, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd13, 32'h0000_1000, 1, 0, 32'h0);
        vecs[3]  = V(1, 5'd12, 32'h0000_FC03, 6'h04, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd12, 32'h0000_FC03, 0, 1, 32'h0);
        vecs[4]  = V(0, 5'd0,  32'h0,         6'h04, 0, 5'd0, 0, 32'h0,       32'h0,      0, 1, 5'd12, 32'h0000_FC01, 1, 0, 32'h0);
        vecs[5]  = V(0, 5'd0,  32'h0,         6'h00, 1, 5'd4, 1, 32'h0000_3010, 32'h3,    1, 0, 5'd14, 32'h0000_300C, 0, 1, 32'h0000_300C);
        vecs[6]  = V(0, 5'd0,  32'h0,         6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd13, 32'h8000_0010, 0, 1, 32'h0000_300C);
        vecs[7]  = V(0, 5'd0,  32'h0,         6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd8,  32'h0000_0003, 0, 1, 32'h0000_300C);
        vecs[8]  = V(0, 5'd0,  32'h0,         6'h00, 1, 5'd8, 0, 32'h0000_4000, 32'h44,   1, 0, 5'd13, 32'h8000_0020, 0, 1, 32'h0000_300C);
        vecs[9]  = V(0, 5'd0,  32'h0,         6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd8,  32'h0000_0044, 0, 1, 32'h0000_300C);
        vecs[10] = V(0, 5'd0,  32'h0,         6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 1, 5'd14, 32'h0000_300C, 0, 0, 32'h0000_300C);
        vecs[11] = V(1, 5'd14, 32'h0000_1234, 6'h00, 1, 5'd0, 0, 32'h0000_2000, 32'h0,    0, 0, 5'd14, 32'h0000_2000, 0, 1, 32'h0000_2000);
        vecs[12] = V(0, 5'd0,  32'h0,         6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 1, 5'd8,  32'h0000_0044, 0, 0, 32'h0000_2000);
        vecs[13] = V(0, 5'd0,  32'h0,         6'h00, 1, 5'd1, 0, 32'h0000_5006, 32'h0,    0, 1, 5'd14, 32'h0000_5004, 0, 1, 32'h0000_5004);
        vecs[14] = V(1, 5'd12, 32'h0000_0401, 6'h00, 1, 5'd2, 0, 32'h0000_7000, 32'h0,    0, 0, 5'd12, 32'h0000_0403, 0, 1, 32'h0000_5004);
        vecs[15] = V(1, 5'd13, 32'h0000_007C, 6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd13, 32'h0000_007C, 0, 1, 32'h0000_5004);
        vecs[16] = V(1, 5'd15, 32'h0000_FFFF, 6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd15, 32'h0000_4E59, 0, 1, 32'h0000_5004);
        vecs[17] = V(1, 5'd8,  32'h0000_0099, 6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd8,  32'h0000_0044, 0, 1, 32'h0000_5004);
        vecs[18] = V(1, 5'd13, 32'hFFFF_FFFF, 6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd13, 32'h8000_007C, 0, 1, 32'h0000_5004);
        vecs[19] = V(0, 5'd0,  32'h0,         6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd10, 32'h0000_0000, 0, 1, 32'h0000_5004);
        vecs[20] = V(1, 5'd9,  32'h0000_0055, 6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd9,  TIMER ? 32'h0000_0055 : 32'h0, 0, 1, 32'h0000_5004);
        vecs[21] = V(1, 5'd14, 32'h0000_ABCD, 6'h00, 0, 5'd0, 0, 32'h0,       32'h0,      0, 0, 5'd14, 32'h0000_ABCC, 0, 1, 32'h0000_ABCC);

        // Reset state, read back between edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd_addr = 5'd12; #1 check("rst.sr", rd_data, 32'h0);
        rd_addr = 5'd13; #1 check("rst.cause", rd_data, 32'h0);
        rd_addr = 5'd14; #1 check("rst.epc", rd_data, 32'h0);
        rd_addr = 5'd15; #1 check("rst.prid", rd_data, 32'h0000_4E59);
        rd_addr = 5'd8;  #1 check("rst.badva", rd_data, 32'h0);
        check("rst.irq", {31'd0, int_req}, 32'd0);
        check("rst.exl", {31'd0, exl_out}, 32'd0);
        check("rst.epc_out", epc_out, 32'h0);

        for (int i = 0; i < 22; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Zero-latency interrupt path from hw_int.
        apply(V(1, 5'd12, 32'h0000_FC01, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd12,
                32'h0000_FC01, 0, 0, 32'h0000_ABCC), "sr_ie");
        @(negedge clk);
        hw_int = 6'b000100;
        #1 check("irq_comb_on", {31'd0, int_req}, 32'd1);
        hw_int = 6'b000000;
        #1 check("irq_comb_off", {31'd0, int_req}, 32'd0);

`ifdef CP0_TIMER_EN
        apply(V(1, 5'd12, 32'h0000_8001, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd12,
                32'h0000_8001, 0, 0, 32'h0000_ABCC), "tm_sr");
        apply(V(1, 5'd11, 32'd10, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd11,
                32'd10, 0, 0, 32'h0000_ABCC), "tm_cmp");
        apply(V(1, 5'd9, 32'd0, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd9,
                32'd0, 0, 0, 32'h0000_ABCC), "tm_cnt");
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (int_req) begin
                n = k;
                break;
            end
        end
        check("tm_latency", n, 11);
        rd_addr = 5'd13;
        #1 check("tm_ti_set", {31'd0, rd_data[30]}, 32'd1);
        apply(V(1, 5'd11, 32'd100, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd13,
                32'h8000_807C, 0, 0, 32'h0000_ABCC), "tm_clr");
        apply(V(1, 5'd9, 32'hFFFF_FFFF, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd9,
                32'hFFFF_FFFF, 0, 0, 32'h0000_ABCC), "tm_max");
        apply(V(0, 5'd0, 32'h0, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd9,
                32'h0, 0, 0, 32'h0000_ABCC), "tm_wrap");
`else
        apply(V(1, 5'd12, 32'h0000_8001, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd12,
                32'h0000_8001, 0, 0, 32'h0000_ABCC), "nt_sr");
        apply(V(1, 5'd11, 32'd0, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd11,
                32'd0, 0, 0, 32'h0000_ABCC), "nt_cmp");
        apply(V(1, 5'd9, 32'd0, 6'h00, 0, 5'd0, 0, 32'h0, 32'h0, 0, 0, 5'd9,
                32'd0, 0, 0, 32'h0000_ABCC), "nt_cnt");
        repeat (12) @(posedge clk);
        #1;
        check("nt_irq", {31'd0, int_req}, 32'd0);
        rd_addr = 5'd13;
        #1 check("nt_cause", rd_data, 32'h8000_007C);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
